// File: rtl/systolic_nxn_array.sv
// Output-stationary NxN systolic matrix multiplier: C = A x B.
// A rows stream in from the left and B columns from the top, both skewed by index.
module systolic_nxn_array #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int ACCW = 2 * DW + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_en,
    input  logic [N*N*DW-1:0]     a_flat,
    input  logic [N*N*DW-1:0]     b_flat,
    output logic [N*N*ACCW-1:0]   c_flat,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = $clog2(3 * N);
    localparam logic [KW-1:0] K_LAST = KW'(3 * N - 2);

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    state_t state, state_next;
    logic   accept, finish;

    logic [KW-1:0]   k;
    logic            sgn;
    logic [DW-1:0]   a_op   [N][N];
    logic [DW-1:0]   b_op   [N][N];
    logic [DW-1:0]   row_a  [N];
    logic [DW-1:0]   col_b  [N];
    logic [DW-1:0]   row_next [N];
    logic [DW-1:0]   col_next [N];
    logic [DW-1:0]   a_pe   [N][N];
    logic [DW-1:0]   b_pe   [N][N];
    logic [DW-1:0]   a_in   [N][N];
    logic [DW-1:0]   b_in   [N][N];
    logic [ACCW-1:0] acc      [N][N];
    logic [ACCW-1:0] acc_next [N][N];
    logic [ACCW-1:0] c_reg    [N][N];

    // Control: start is only looked at in IDLE; the last FEED edge hands back to IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                if (k == K_LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign busy = (state == FEED);

    // Skewed injectors: row i carries A[i][k-i], column j carries B[k-j][j], zero outside.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            row_next[i] = '0;
            col_next[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (k == KW'(i + j)) begin
                    row_next[i] = a_op[i][j];
                    col_next[i] = b_op[j][i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [ACCW-1:0] ea, eb;
            if (gj == 0) begin : g_a_edge
                assign a_in[gi][gj] = row_a[gi];
            end else begin : g_a_fwd
                assign a_in[gi][gj] = a_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in[gi][gj] = col_b[gj];
            end else begin : g_b_fwd
                assign b_in[gi][gj] = b_pe[gi-1][gj];
            end
            // Extending both operands to ACCW makes the truncated product exact in either mode.
            assign ea = {{(ACCW-DW){sgn & a_in[gi][gj][DW-1]}}, a_in[gi][gj]};
            assign eb = {{(ACCW-DW){sgn & b_in[gi][gj][DW-1]}}, b_in[gi][gj]};
            assign acc_next[gi][gj] = acc[gi][gj] + ea * eb;
            assign c_flat[(gi*N+gj)*ACCW +: ACCW] = c_reg[gi][gj];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k    <= '0;
            sgn  <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < N; i++) begin
                row_a[i] <= '0;
                col_b[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    a_op[i][j]  <= '0;
                    b_op[i][j]  <= '0;
                    a_pe[i][j]  <= '0;
                    b_pe[i][j]  <= '0;
                    acc[i][j]   <= '0;
                    c_reg[i][j] <= '0;
                end
            end
        end else begin
            done <= finish;
            if (accept) begin
                k   <= '0;
                sgn <= signed_en;
                for (int i = 0; i < N; i++) begin
                    row_a[i] <= '0;
                    col_b[i] <= '0;
                    for (int j = 0; j < N; j++) begin
                        a_op[i][j] <= a_flat[(i*N+j)*DW +: DW];
                        b_op[i][j] <= b_flat[(i*N+j)*DW +: DW];
                        a_pe[i][j] <= '0;
                        b_pe[i][j] <= '0;
                        acc[i][j]  <= '0;
                    end
                end
            end else if (state == FEED) begin
                k     <= k + KW'(1);
                row_a <= row_next;
                col_b <= col_next;
                a_pe  <= a_in;
                b_pe  <= b_in;
                acc   <= acc_next;
                // The final product lands on this same edge, so publish the post-add value.
                if (finish) c_reg <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_systolic_nxn_array.sv
// Bench for systolic_nxn_array: an N=2 and an N=4 instance checked against a bench-side matrix model.
module tb_systolic_nxn_array;

    localparam int ACC2 = 17;
    localparam int ACC4 = 18;

    logic clk;
    logic rst2, start2, sgn2, busy2, done2;
    logic [31:0]  a2, b2;
    logic [67:0]  c2;
    logic rst4, start4, sgn4, busy4, done4;
    logic [127:0] a4, b4;
    logic [287:0] c4;

    logic [67:0]  exp2_q[$];
    logic [287:0] exp4_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    systolic_nxn_array #(.N(2), .DW(8)) dut2 (
        .clk(clk), .reset(rst2), .start(start2), .signed_en(sgn2),
        .a_flat(a2), .b_flat(b2), .c_flat(c2), .busy(busy2), .done(done2)
    );

    systolic_nxn_array #(.N(4), .DW(8)) dut4 (
        .clk(clk), .reset(rst4), .start(start4), .signed_en(sgn4),
        .a_flat(a4), .b_flat(b4), .c_flat(c4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint elem(input logic [7:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'({1'b0, v});
    endfunction

    function automatic logic [67:0] model2(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [67:0] c = '0;
        longint sum;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                sum = 0;
                for (int t = 0; t < 2; t++)
                    sum += elem(a[(i*2+t)*8 +: 8], s) * elem(b[(t*2+j)*8 +: 8], s);
                c[(i*2+j)*ACC2 +: ACC2] = sum[ACC2-1:0];
            end
        return c;
    endfunction

    function automatic logic [287:0] model4(input logic [127:0] a, input logic [127:0] b, input logic s);
        logic [287:0] c = '0;
        longint sum;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                sum = 0;
                for (int t = 0; t < 4; t++)
                    sum += elem(a[(i*4+t)*8 +: 8], s) * elem(b[(t*4+j)*8 +: 8], s);
                c[(i*4+j)*ACC4 +: ACC4] = sum[ACC4-1:0];
            end
        return c;
    endfunction

    task automatic pulse_start2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    // Edges counted after the accept edge until done is seen; -1 on timeout.
    task automatic wait_done2(output int cycles, output int busy_cnt);
        busy_cnt = 0;
        cycles   = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done2) begin
                cycles = c;
                break;
            end
            if (busy2) busy_cnt++;
        end
    endtask

    task automatic wait_done4(output int cycles, output int busy_cnt);
        busy_cnt = 0;
        cycles   = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done4) begin
                cycles = c;
                break;
            end
            if (busy4) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 6;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got %b want 0", busy2); end
        if (done2 !== 1'b0) begin n_fail++; $display("FAIL reset_done2 got %b want 0", done2); end
        if (c2 !== 68'd0)   begin n_fail++; $display("FAIL reset_c2 got %h want 0", c2); end
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got %b want 0", done4); end
        if (c4 !== 288'd0)  begin n_fail++; $display("FAIL reset_c4 got %h want 0", c4); end
        rst2 = 1'b0; rst4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 2;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("FAIL idle2 busy=%b done=%b want 0 0", busy2, done2); end
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL idle4 busy=%b done=%b want 0 0", busy4, done4); end
    endtask

    task automatic test_basic_unsigned();
        int cyc, bcnt;
        logic [67:0] exp;
        a2 = {8'd4, 8'd3, 8'd2, 8'd1};
        b2 = {8'd8, 8'd7, 8'd6, 8'd5};
        sgn2 = 1'b0;
        exp2_q.push_back(model2(a2, b2, sgn2));
        pulse_start2();
        n_checks++;
        if (busy2 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_accept got %b want 1", busy2); end
        wait_done2(cyc, bcnt);
        n_checks += 4;
        if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", cyc); end
        if (bcnt + 1 !== 5) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 5", bcnt + 1); end
        exp = exp2_q.pop_front();
        if (c2 !== exp) begin n_fail++; $display("FAIL basic_c_model got %h want %h", c2, exp); end
        if (c2 !== {17'd50, 17'd43, 17'd22, 17'd19}) begin n_fail++; $display("FAIL basic_c_const got %h want 19,22,43,50", c2); end
        @(posedge clk); #1;
        n_checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width done=%b busy=%b want 0 0", done2, busy2); end
    endtask

    task automatic test_signed();
        int cyc, bcnt;
        logic [67:0] exp;
        a2 = {8'hFC, 8'h03, 8'h02, 8'hFF};
        b2 = {8'd1, 8'd0, 8'd0, 8'd1};
        sgn2 = 1'b1;
        exp2_q.push_back(model2(a2, b2, sgn2));
        pulse_start2();
        sgn2 = 1'b0;
        wait_done2(cyc, bcnt);
        exp = exp2_q.pop_front();
        n_checks += 3;
        if (cyc !== 5) begin n_fail++; $display("FAIL signed_latency got %0d want 5", cyc); end
        if (c2 !== exp) begin n_fail++; $display("FAIL signed_c_model got %h want %h", c2, exp); end
        if (c2 !== {17'h1FFFC, 17'd3, 17'd2, 17'h1FFFF}) begin n_fail++; $display("FAIL signed_c_const got %h", c2); end
    endtask

    task automatic test_full_scale();
        int cyc, bcnt;
        logic [287:0] want;
        for (int e = 0; e < 16; e++) want[e*ACC4 +: ACC4] = 18'h3F804;
        a4 = '1; b4 = '1; sgn4 = 1'b0;
        exp4_q.push_back(model4(a4, b4, sgn4));
        pulse_start4();
        wait_done4(cyc, bcnt);
        n_checks += 4;
        if (cyc !== 11) begin n_fail++; $display("FAIL full_latency got %0d want 11", cyc); end
        if (bcnt + 1 !== 11) begin n_fail++; $display("FAIL full_busy_cycles got %0d want 11", bcnt + 1); end
        if (c4 !== want) begin n_fail++; $display("FAIL full_c_const got %h", c4); end
        want = exp4_q.pop_front();
        if (c4 !== want) begin n_fail++; $display("FAIL full_c_model got %h want %h", c4, want); end
    endtask

    task automatic test_random();
        int cyc, bcnt;
        logic [67:0]  e2;
        logic [287:0] e4;
        for (int r = 0; r < 4; r++) begin
            a2 = $urandom(); b2 = $urandom(); sgn2 = 1'($urandom_range(0, 1));
            exp2_q.push_back(model2(a2, b2, sgn2));
            pulse_start2();
            a2 = $urandom(); b2 = $urandom();
            wait_done2(cyc, bcnt);
            e2 = exp2_q.pop_front();
            n_checks += 2;
            if (cyc !== 5) begin n_fail++; $display("FAIL rand2_latency[%0d] got %0d want 5", r, cyc); end
            if (c2 !== e2) begin n_fail++; $display("FAIL rand2_c[%0d] got %h want %h", r, c2, e2); end

            for (int w = 0; w < 4; w++) begin
                a4[w*32 +: 32] = $urandom();
                b4[w*32 +: 32] = $urandom();
            end
            sgn4 = 1'($urandom_range(0, 1));
            exp4_q.push_back(model4(a4, b4, sgn4));
            pulse_start4();
            a4 = ~a4;
            wait_done4(cyc, bcnt);
            e4 = exp4_q.pop_front();
            n_checks += 2;
            if (cyc !== 11) begin n_fail++; $display("FAIL rand4_latency[%0d] got %0d want 11", r, cyc); end
            if (c4 !== e4) begin n_fail++; $display("FAIL rand4_c[%0d] got %h want %h", r, c4, e4); end
        end
    endtask

    task automatic test_back_to_back();
        logic [67:0] e1, e2, got;
        logic [31:0] a_n, b_n;
        int d1, d2;
        d1 = -1; d2 = -1;
        a2 = $urandom(); b2 = $urandom(); sgn2 = 1'b0;
        a_n = $urandom(); b_n = $urandom();
        e1 = model2(a2, b2, 1'b0);
        exp2_q.push_back(e1);
        exp2_q.push_back(model2(a_n, b_n, 1'b1));
        start2 = 1'b1;
        @(posedge clk); #1;
        a2 = a_n; b2 = b_n; sgn2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done2) begin
                got = exp2_q.pop_front();
                n_checks++;
                if (c2 !== got) begin n_fail++; $display("FAIL b2b_c at cycle %0d got %h want %h", c, c2, got); end
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    start2 = 1'b0;
                    break;
                end
            end else if (d1 >= 0) begin
                n_checks++;
                if (c2 !== e1) begin n_fail++; $display("FAIL b2b_hold at cycle %0d got %h want %h", c, c2, e1); end
            end
        end
        start2 = 1'b0;
        sgn2 = 1'b0;
        n_checks += 2;
        if (d1 !== 5) begin n_fail++; $display("FAIL b2b_first_done got %0d want 5", d1); end
        if (d2 - d1 !== 6) begin n_fail++; $display("FAIL b2b_spacing got %0d want 6", d2 - d1); end
        @(posedge clk); #1;
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third got busy %b want 0", busy2); end
    endtask

    task automatic test_ignore_start();
        int cyc, bcnt, extra;
        logic [67:0] exp;
        a2 = $urandom(); b2 = $urandom(); sgn2 = 1'b0;
        exp2_q.push_back(model2(a2, b2, sgn2));
        pulse_start2();
        @(posedge clk); #1;
        a2 = ~a2; b2 = ~b2; sgn2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_done2(cyc, bcnt);
        exp = exp2_q.pop_front();
        n_checks += 2;
        if (cyc + 2 !== 5) begin n_fail++; $display("FAIL ignore_latency got %0d want 5", cyc + 2); end
        if (c2 !== exp) begin n_fail++; $display("FAIL ignore_c got %h want %h", c2, exp); end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done2 || busy2) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_activity got %0d want 0", extra); end
        sgn2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt, stray;
        logic [127:0] ident;
        logic [287:0] want, exp;
        for (int w = 0; w < 4; w++) begin
            a4[w*32 +: 32] = $urandom();
            b4[w*32 +: 32] = $urandom();
        end
        sgn4 = 1'b0;
        pulse_start4();
        repeat (5) @(posedge clk);
        #3;
        n_checks++;
        if (busy4 !== 1'b1 || c4 === 288'd0) begin n_fail++; $display("FAIL rstmid_pre busy=%b c_zero=%b want 1 0", busy4, c4 === 288'd0); end
        rst4 = 1'b1;
        #1;
        n_checks += 3;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy4); end
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done4); end
        if (c4 !== 288'd0)  begin n_fail++; $display("FAIL rstmid_c got %h want 0", c4); end
        @(posedge clk); #1;
        rst4 = 1'b0;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done4 || busy4) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL rstmid_stray_activity got %0d want 0", stray); end
        ident = '0;
        want  = '0;
        for (int d = 0; d < 4; d++) begin
            ident[(d*4+d)*8 +: 8] = 8'd1;
            want[(d*4+d)*ACC4 +: ACC4] = 18'd1;
        end
        a4 = ident; b4 = ident;
        exp4_q.push_back(model4(a4, b4, sgn4));
        pulse_start4();
        wait_done4(cyc, bcnt);
        exp = exp4_q.pop_front();
        n_checks += 3;
        if (cyc !== 11) begin n_fail++; $display("FAIL rstmid_latency got %0d want 11", cyc); end
        if (c4 !== want) begin n_fail++; $display("FAIL rstmid_ident_const got %h", c4); end
        if (c4 !== exp)  begin n_fail++; $display("FAIL rstmid_ident_model got %h want %h", c4, exp); end
    endtask

    initial begin
        start2 = 1'b0; sgn2 = 1'b0; a2 = '0; b2 = '0; rst2 = 1'b1;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0; rst4 = 1'b1;
        test_reset();
        test_basic_unsigned();
        test_signed();
        test_full_scale();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        n_checks++;
        if (exp2_q.size() != 0 || exp4_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d/%0d want 0/0", exp2_q.size(), exp4_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_nxn_array.md
SYSTOLIC_NXN_ARRAY -- requirements
Module: systolic_nxn_array

Interface
REQ-001 Parameter N, default 4, array dimension (NxN PEs, NxN operand matrices), N >= 2.
REQ-002 Parameter DW, default 8, operand element width in bits.
REQ-003 Parameter ACCW, default 2*DW+$clog2(N), accumulator and result element width, ACCW >= 2*DW+$clog2(N).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-007 signed_en  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 a_flat  input  N*N*DW  matrix A; element A[i][j] at bits [(i*N+j)*DW +: DW].
REQ-009 b_flat  input  N*N*DW  matrix B, same packing as a_flat.
REQ-010 c_flat  output  N*N*ACCW  result C = A x B; C[i][j] at bits [(i*N+j)*ACCW +: ACCW].
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse marking c_flat updated with a new result.

Function
REQ-013 Control FSM SHALL have states IDLE and FEED; reset enters IDLE.
REQ-014 IDLE, start=1 at an edge: a_flat, b_flat, signed_en captured into internal registers, all PE accumulators and skew registers cleared, feed counter k <= 0, state <= FEED, busy <= 1.
REQ-015 IDLE, start=0: no state change; c_flat held.
REQ-016 FEED, each edge: row injector i loads A[i][k-i] when 0 <= k-i < N, else 0; column injector j loads B[k-j][j] when 0 <= k-j < N, else 0; k <= k+1.
REQ-017 PE[i][j] SHALL take a from row injector i (j=0) or PE[i][j-1] a-register, b from column injector j (i=0) or PE[i-1][j] b-register; each edge it registers a and b for forwarding and performs acc <= acc + a*b.
REQ-018 Products SHALL be sign-extended (signed_en=1) or zero-extended (signed_en=0) to ACCW before accumulation; no saturation, no overflow possible given REQ-003.
REQ-019 FEED, edge with k = 3N-2: final accumulation occurs, all C[i][j] copied into c_flat registers, done <= 1, busy <= 0, state <= IDLE.
REQ-020 Latency: done SHALL be high in the cycle following the edge exactly 3N-1 edges after the start-accept edge (N=2: 5, N=4: 11).
REQ-021 done SHALL be high for exactly one cycle per completed operation.
REQ-022 start while busy=1 SHALL be ignored (no queueing, no restart); operand inputs may change freely while busy.
REQ-023 start high at the same edge done is issued SHALL not be accepted (FSM is leaving FEED); start accepted earliest on the next edge, i.e. back-to-back ops every 3N cycles.
REQ-024 c_flat SHALL remain stable from one done until the next done; accumulators are internal and not visible.

Reset
REQ-025 reset asserted: immediately (without clock) state=IDLE, busy=0, done=0, c_flat=0, k=0, all accumulators, skew and operand registers 0.
REQ-026 reset mid-FEED: operation aborted, no done pulse, c_flat=0; next start after release runs a full operation normally.

Verification
REQ-027 N=2, DW=8, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start one cycle -> busy 1 for 5 cycles, done pulses at edge 5, C=[[19,22],[43,50]].
REQ-028 N=2, DW=8, signed_en=1, A=[[-1,2],[3,-4]] (0xFF,0x02,0x03,0xFC), B=identity -> C=[[0x1FFFF,2],[3,0x1FFFC]] (ACCW=17).
REQ-029 N=4, DW=8, unsigned, all elements 0xFF -> every C[i][j]=260100 (0x3F804), no wrap, done 11 cycles after start.
REQ-030 N=2: start held high continuously across two operations with new operands -> second op accepted the edge after first done, two done pulses 6 cycles apart, c_flat holds op1 result until op2 done.
REQ-031 N=2: start pulsed again at cycle 2 of an operation -> ignored, single done at edge 5 with original result.
REQ-032 N=4: reset asserted at cycle 6 of FEED -> busy, done, c_flat 0 immediately; after release new start with A=B=identity -> C=identity, done 11 cycles later.
